// File: rtl/led_matrix_scan.sv
// 8x8 row-scanned LED matrix driver with a double-buffered frame memory.
// The back buffer becomes the front only at a frame boundary, so a frame never tears.
module led_matrix_scan #(
    parameter int CLK_FREQ     = 12_000_000,
    parameter int SCAN_FREQ    = 1000,
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic       frame_swap,
    output logic       swap_done,
    output logic       frame_start,
    output logic [7:0] row_out,
    output logic [7:0] col_out
);

    localparam int ROW_CNT = CLK_FREQ / SCAN_FREQ / ROWS - 1;
    localparam int CNT_W   = (ROW_CNT < 1) ? 1 : $clog2(ROW_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ROW_CNT);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       row;
    logic             front_sel;
    logic             pending;
    logic [COLS-1:0]  mem [2][ROWS];

    logic wrap;
    logic boundary;

    assign wrap     = (cnt == CNT_LAST);
    // Edge that processes count 0 of row 0: outputs enter row 0's slot here.
    assign boundary = (cnt == '0) && (row == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BLANK;
            cnt         <= '0;
            row         <= '0;
            front_sel   <= 1'b0;
            pending     <= 1'b0;
            wr_ready    <= 1'b1;
            swap_done   <= 1'b0;
            frame_start <= 1'b0;
            row_out     <= '1;
            col_out     <= '0;
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned r = 0; r < ROWS; r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                row <= row + 1'b1;
            end

            // state tracks the current count: DRIVE iff cnt >= BLANK_CYCLES
            case (state)
                BLANK:   if (cnt == BLANK_LAST) state <= DRIVE;
                DRIVE:   if (wrap) state <= BLANK;
                default: state <= BLANK;
            endcase

            if (state == DRIVE) begin
                row_out <= ~(8'h01 << row);
                col_out <= mem[front_sel][row];
            end else begin
                row_out <= '1;
                col_out <= '0;
            end

            frame_start <= boundary;
            swap_done   <= 1'b0;

            if (wr_en && wr_ready) begin
                mem[~front_sel][wr_row] <= wr_data;
            end

            // A request arriving on the boundary edge only arms; it applies one frame later.
            if (pending) begin
                if (boundary) begin
                    pending   <= 1'b0;
                    wr_ready  <= 1'b1;
                    front_sel <= ~front_sel;
                    swap_done <= 1'b1;
                end
            end else if (frame_swap) begin
                pending  <= 1'b1;
                wr_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: cycle-count model of scan timing and buffer swaps,
// checked every cycle, plus directed literal expectations.
module tb_led_matrix_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en = 1'b0;
    logic [2:0] wr_row = '0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;
    logic       frame_swap = 1'b0;
    logic       swap_done;
    logic       frame_start;
    logic [7:0] row_out;
    logic [7:0] col_out;

    led_matrix_scan #(
        .CLK_FREQ(8000),
        .SCAN_FREQ(125),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_row(wr_row),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .frame_swap(frame_swap),
        .swap_done(swap_done),
        .frame_start(frame_start),
        .row_out(row_out),
        .col_out(col_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: k = clock edges since reset release; slot position follows from k alone.
    int         k;
    int         pos, ph, rr;
    logic [7:0] mbuf [2][8];
    bit         msel, mpend;
    logic [7:0] e_row, e_col;
    logic       e_ready, e_sd, e_fs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k = 0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++)
                    mbuf[b][r] = 8'h00;
            msel = 1'b0;
            mpend = 1'b0;
            e_row = 8'hFF;
            e_col = 8'h00;
            e_ready = 1'b1;
            e_sd = 1'b0;
            e_fs = 1'b0;
        end else begin
            k++;
            pos = (k - 1) % 64;
            ph = pos % 8;
            rr = pos / 8;
            e_fs = (pos == 0);
            e_row = (ph < 2) ? 8'hFF : ~(8'h01 << rr);
            e_col = (ph < 2) ? 8'h00 : mbuf[msel][rr];
            e_sd = 1'b0;
            if (wr_en && e_ready) mbuf[!msel][wr_row] = wr_data;
            if (mpend) begin
                if (pos == 0) begin
                    mpend = 1'b0;
                    msel = !msel;
                    e_sd = 1'b1;
                end
            end else if (frame_swap) begin
                mpend = 1'b1;
            end
            e_ready = !mpend;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("row_out", row_out, e_row);
            check("col_out", col_out, e_col);
            check("wr_ready", {7'b0, wr_ready}, {7'b0, e_ready});
            check("swap_done", {7'b0, swap_done}, {7'b0, e_sd});
            check("frame_start", {7'b0, frame_start}, {7'b0, e_fs});
            check("row_onehot", {7'b0, ($countones(~row_out) <= 1)}, 8'h01);
        end
    end

    task automatic wait_k(input int target);
        int guard = 0;
        while (k != target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (k != target) begin
            checks++;
            failures++;
            $display("FAIL wait_k actual=%0d expected=%0d", k, target);
        end
    endtask

    initial begin
        rst = 1'b1;
        #1 check_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_row", row_out, 8'hFF);
        check("rst_col", col_out, 8'h00);
        rst = 1'b0;

        wait_k(1);
        check("fs_first", {7'b0, frame_start}, 8'h01);
        check("row_first", row_out, 8'hFF);
        wait_k(3);
        check("row0_drive", row_out, 8'hFE);
        wait_k(11);
        check("row1_drive", row_out, 8'hFD);

        wait_k(12);
        wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'hA5;
        wait_k(13);
        wr_en = 1'b0; frame_swap = 1'b1;
        wait_k(14);
        frame_swap = 1'b0;
        check("ready_low", {7'b0, wr_ready}, 8'h00);
        wr_en = 1'b1; wr_row = 3'd5; wr_data = 8'hFF;
        wait_k(15);
        wr_en = 1'b0;
        wait_k(20);
        frame_swap = 1'b1;
        wait_k(21);
        frame_swap = 1'b0;

        wait_k(65);
        check("swap1_done", {7'b0, swap_done}, 8'h01);
        check("swap1_ready", {7'b0, wr_ready}, 8'h01);
        check("swap1_fs", {7'b0, frame_start}, 8'h01);
        wait_k(66);
        check("swap1_once", {7'b0, swap_done}, 8'h00);
        wait_k(91);
        check("row3_row", row_out, 8'hF7);
        check("row3_col", col_out, 8'hA5);

        wait_k(100);
        wr_en = 1'b1; wr_row = 3'd1; wr_data = 8'h3C; frame_swap = 1'b1;
        wait_k(101);
        wr_en = 1'b0; frame_swap = 1'b0;
        wait_k(107);
        check("row5_col", col_out, 8'h00);
        wait_k(139);
        check("swap2_row1", col_out, 8'h3C);
        wait_k(155);
        check("swap2_row3", col_out, 8'h00);

        wait_k(192);
        frame_swap = 1'b1;
        wait_k(193);
        frame_swap = 1'b0;
        check("bnd_no_swap", {7'b0, swap_done}, 8'h00);
        check("bnd_pending", {7'b0, wr_ready}, 8'h00);
        wait_k(257);
        check("bnd_swap", {7'b0, swap_done}, 8'h01);

        wait_k(260);
        frame_swap = 1'b1;
        wait_k(261);
        frame_swap = 1'b0;
        wait_k(300);
        check("pre_rst_row", row_out, 8'hDF);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_row", row_out, 8'hFF);
        check("mid_rst_col", col_out, 8'h00);
        check("mid_rst_ready", {7'b0, wr_ready}, 8'h01);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        wait_k(1);
        check("fs_after_rst", {7'b0, frame_start}, 8'h01);
        wait_k(64);
        check("no_stale_swap", {7'b0, swap_done}, 8'h00);
        wait_k(65);
        check("no_stale_swap2", {7'b0, swap_done}, 8'h00);
        wait_k(70);
        frame_swap = 1'b1;
        wait_k(71);
        frame_swap = 1'b0;
        wait_k(129);
        check("post_rst_swap", {7'b0, swap_done}, 8'h01);
        wait_k(131);
        frame_swap = 1'b1;
        wait_k(132);
        frame_swap = 1'b0;
        wait_k(193);
        check("post_rst_swap2", {7'b0, swap_done}, 8'h01);
        wait_k(250);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
